udma_spis_pingpong_ctrl: RTL and testbench
==========================================

Name: udma_spis_pingpong_ctrl

Overview:
- Autonomous sequencer that acts as a master on the SPI-slave uDMA channel config bus (5-bit addr, rwn, valid/ready).
- Arms RX and TX channels on one of two buffer sets (ping/pong). On each slave end-of-transfer pulse it reports the finished buffer and re-arms the other buffer, so no CPU is needed between SPI frames.
- Sits between the subsystem CPU config registers and the SPI-slave channel register interface.

Parameters:
L2_AWIDTH_NOAL, 12, width of L2 buffer start addresses
TRANS_SIZE, 16, width of transfer size fields

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
enable_i  in  1  level; 1 = run ping-pong, 0 = stop and clear channels
rx_addr0_i / rx_addr1_i  in  L2_AWIDTH_NOAL each  RX start address, buffer 0 / buffer 1
tx_addr0_i / tx_addr1_i  in  L2_AWIDTH_NOAL each  TX start address, buffer 0 / buffer 1
rx_size_i / tx_size_i  in  TRANS_SIZE each  RX / TX bytes per buffer (same for both buffers)
seot_i  in  1  single-cycle slave end-of-transfer pulse
cfg_data_o  out  32  config write data
cfg_addr_o  out  5  config register address
cfg_valid_o  out  1  config request valid
cfg_rwn_o  out  1  1 = read, 0 = write
cfg_data_i  in  32  config read data (same cycle as ready)
cfg_ready_i  in  1  request accepted
busy_o  out  1  programming sequence in progress
armed_o  out  1  both channels armed, waiting for seot_i
active_buf_o  out  1  buffer index currently armed or being armed
done_valid_o  out  1  one-cycle pulse: a buffer completed
done_buf_o  out  1  index of completed buffer; valid with done_valid_o
xfer_cnt_o  out  16  completed-buffer counter, wraps 0xFFFF -> 0
overrun_o  out  1  sticky: seot_i arrived while a seot was already pending
rx_len_o  out  TRANS_SIZE  received byte count (UDMA_SPIS_PP_READBACK_EN only; 0 otherwise)

Behaviour:
- Reset: every output 0; state IDLE; seot-pending flag 0.
- Config addresses and data:
  - 0x00 RX_SADDR, 0x01 RX_SIZE, 0x02 RX_CFG, 0x04 TX_SADDR, 0x05 TX_SIZE, 0x06 TX_CFG.
  - CFG enable word = 0x10 (bit4). CFG clear word = 0x40 (bit6). Continuous bit is always 0.
  - Address and size data are zero-extended to 32 bits.
- States: IDLE, [RD_LEN], W_RXA, W_RXS, W_RXC, W_TXA, W_TXS, W_TXC, ARMED, C_RX, C_TX.
- Bus handshake:
  - In each W_/C_/RD_ state, cfg_valid_o=1 and addr/data/rwn are driven from registers.
  - All three are held stable until cfg_ready_i. The state advances on the cycle valid&ready is seen.
  - Exactly one transfer per state. cfg_valid_o=0 in IDLE and ARMED.
- IDLE: when enable_i=1, set active_buf_o=0 and go to W_RXA. The sequence is W_RXA → W_RXS → W_RXC → W_TXA → W_TXS → W_TXC → ARMED. Addresses are selected by active_buf_o.
- busy_o=1 in every state except IDLE and ARMED. armed_o=1 only in ARMED.
- ARMED with seot_i=1 (or pending flag set):
  - Next cycle: done_valid_o=1, done_buf_o=active_buf_o, xfer_cnt_o incremented, active_buf_o toggled, pending flag cleared.
  - Then go to W_RXA (or RD_LEN when readback is enabled). Latency from seot_i to the first cfg_valid_o is 1 cycle.
- seot_i outside ARMED and outside IDLE:
  - Sets the pending flag, which is serviced on entry to ARMED.
  - If the flag is already set, overrun_o is set instead and the extra pulse is dropped.
  - seot_i in IDLE is ignored.
- overrun_o clears only on reset or on an enable_i 0→1 transition.
- enable_i=0 while not IDLE:
  - Any in-flight write completes its handshake, then the block goes to C_RX (RX_CFG=0x40), then C_TX (TX_CFG=0x40), then IDLE.
  - Pending flag cleared. Counters are kept.
- enable_i=0 in the same cycle as seot_i in ARMED: the completion is still reported (done pulse, counter), then the block takes the clear path instead of re-arming.
- enable_i re-asserted during C_RX/C_TX: the clear sequence finishes, then IDLE restarts at buffer 0.
- Reset mid-handshake: the request is dropped immediately (valid=0). The target must tolerate this.

Optional Feature:
UDMA_SPIS_PP_READBACK_EN
- Defined: after a completion, the block reads RX_SIZE (addr 0x01, rwn=1) in RD_LEN before re-arming.
  - rx_len_o = rx_size_i − cfg_data_i[TRANS_SIZE-1:0] (modulo 2^TRANS_SIZE).
  - rx_len_o is registered on ready; done_valid_o pulses in the cycle after the read completes.
  - On the disable path the read is still performed before C_RX.
- Undefined: no RD_LEN state, no read transfers ever issued, rx_len_o tied 0, cfg_rwn_o tied 0.

Test Plan:
- Arm: rx_addr0=0x100, rx_size=0x20, tx_addr0=0x200, tx_size=0x20, ready always 1, enable 0→1 → six writes in order: (0x00,0x100), (0x01,0x20), (0x02,0x10), (0x04,0x200), (0x05,0x20), (0x06,0x10); then armed_o=1.
- Ping-pong: after arming, seot pulse → done_buf_o=0, xfer_cnt_o=1, writes use rx_addr1/tx_addr1. A second seot → done_buf_o=1, xfer_cnt_o=2, buffer 0 re-armed.
- Backpressure: ready low 3 cycles on each request → valid/addr/data stable throughout; still exactly 6 writes.
- Overrun: two seot pulses during one programming sequence → one extra completion after ARMED, overrun_o=1. enable 0→1 clears it.
- Disable: enable=0 in ARMED → writes (0x02,0x40), (0x06,0x40), then IDLE, busy_o=0.
- Readback (macro on): rx_size=0x20, read returns 0x08 → rx_len_o=0x18 coincident with done_valid_o.

Source files
------------

// File: rtl/udma_spis_pingpong_ctrl.sv
// udma_spis_pingpong_ctrl
//   Ping-pong sequencer for the SPI-slave uDMA channel config bus. It arms the
//   RX and TX channels on buffer set 0 or 1. On each slave end-of-transfer it
//   reports the finished buffer and re-arms the other set, with no CPU help.
//
//   Optional build macro: UDMA_SPIS_PP_READBACK_EN
//     When defined, the block reads RX_SIZE after each completion and reports
//     rx_len_o = rx_size_i - remaining. When undefined, no reads are issued,
//     rx_len_o is 0 and cfg_rwn_o is 0.
//
//   Ports
//     clk_i, rstn_i                  clock, async active-low reset
//     enable_i                       1 = run ping-pong, 0 = clear channels and stop
//     rx_addr0/1_i, tx_addr0/1_i     L2 start addresses for buffer 0/1
//     rx_size_i, tx_size_i           bytes per buffer
//     seot_i                         slave end-of-transfer pulse
//     cfg_*_o / cfg_data_i / cfg_ready_i   config bus master (valid/ready)
//     busy_o, armed_o, active_buf_o  sequencer status
//     done_valid_o, done_buf_o       completion pulse and buffer index
//     xfer_cnt_o, overrun_o          completion counter, sticky lost-seot flag
//     rx_len_o                       received byte count (readback build only)
//
//   state   | meaning
//   IDLE    | channels cleared, waiting for enable_i
//   W_RXA   | write RX start address
//   W_RXS   | write RX size
//   W_RXC   | write RX cfg (enable)
//   W_TXA   | write TX start address
//   W_TXS   | write TX size
//   W_TXC   | write TX cfg (enable)
//   ARMED   | both channels armed, waiting for seot_i
//   RD_LEN  | read back RX_SIZE (readback build only)
//   C_RX    | write RX cfg (clear)
//   C_TX    | write TX cfg (clear)
module udma_spis_pingpong_ctrl #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      enable_i,
  input  logic [L2_AWIDTH_NOAL-1:0] rx_addr0_i,
  input  logic [L2_AWIDTH_NOAL-1:0] rx_addr1_i,
  input  logic [L2_AWIDTH_NOAL-1:0] tx_addr0_i,
  input  logic [L2_AWIDTH_NOAL-1:0] tx_addr1_i,
  input  logic [TRANS_SIZE-1:0]     rx_size_i,
  input  logic [TRANS_SIZE-1:0]     tx_size_i,
  input  logic                      seot_i,
  output logic [31:0]               cfg_data_o,
  output logic [4:0]                cfg_addr_o,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i,
  output logic                      busy_o,
  output logic                      armed_o,
  output logic                      active_buf_o,
  output logic                      done_valid_o,
  output logic                      done_buf_o,
  output logic [15:0]               xfer_cnt_o,
  output logic                      overrun_o,
  output logic [TRANS_SIZE-1:0]     rx_len_o
);

  localparam logic [4:0]  ADDR_RX_SADDR = 5'h00;
  localparam logic [4:0]  ADDR_RX_SIZE  = 5'h01;
  localparam logic [4:0]  ADDR_RX_CFG   = 5'h02;
  localparam logic [4:0]  ADDR_TX_SADDR = 5'h04;
  localparam logic [4:0]  ADDR_TX_SIZE  = 5'h05;
  localparam logic [4:0]  ADDR_TX_CFG   = 5'h06;
  localparam logic [31:0] CFG_EN        = 32'h0000_0010;
  localparam logic [31:0] CFG_CLR       = 32'h0000_0040;

  typedef enum logic [3:0] {
    S_IDLE, S_W_RXA, S_W_RXS, S_W_RXC, S_W_TXA, S_W_TXS, S_W_TXC,
    S_ARMED, S_C_RX, S_C_TX
`ifdef UDMA_SPIS_PP_READBACK_EN
    , S_RD_LEN
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        buf_q, buf_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic        en_q;
  logic        done_q, done_d;
  logic        done_buf_q, done_buf_d;
  logic [15:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        hs;
  logic        complete;
  logic        unused_cfg_data;
`ifdef UDMA_SPIS_PP_READBACK_EN
  logic                  rwn_q, rwn_d;
  logic [TRANS_SIZE-1:0] rx_len_q, rx_len_d;
`endif

  assign hs              = valid_q & cfg_ready_i;
  assign unused_cfg_data = ^cfg_data_i;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    pend_d     = pend_q;
    ovr_d      = ovr_q;
    done_d     = 1'b0;
    done_buf_d = done_buf_q;
    cnt_d      = cnt_q;
    complete   = 1'b0;
`ifdef UDMA_SPIS_PP_READBACK_EN
    rx_len_d   = rx_len_q;
`endif

    if (enable_i && !en_q) ovr_d = 1'b0;
    // A seot while busy is remembered once; a second one is lost and flagged.
    if (seot_i && state_q != S_IDLE && state_q != S_ARMED) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE:  if (enable_i) begin
                 state_d = S_W_RXA;
                 buf_d   = 1'b0;
               end
      S_W_RXA: if (hs) state_d = enable_i ? S_W_RXS : S_C_RX;
      S_W_RXS: if (hs) state_d = enable_i ? S_W_RXC : S_C_RX;
      S_W_RXC: if (hs) state_d = enable_i ? S_W_TXA : S_C_RX;
      S_W_TXA: if (hs) state_d = enable_i ? S_W_TXS : S_C_RX;
      S_W_TXS: if (hs) state_d = enable_i ? S_W_TXC : S_C_RX;
      S_W_TXC: if (hs) state_d = enable_i ? S_ARMED : S_C_RX;
      S_ARMED: begin
        if (seot_i || pend_q) begin
          // servicing the pending flag while a fresh seot arrives keeps one pending
          pend_d = pend_q & seot_i;
`ifdef UDMA_SPIS_PP_READBACK_EN
          state_d = S_RD_LEN;
`else
          complete = 1'b1;
          state_d  = enable_i ? S_W_RXA : S_C_RX;
`endif
        end else if (!enable_i) begin
          state_d = S_C_RX;
        end
      end
`ifdef UDMA_SPIS_PP_READBACK_EN
      S_RD_LEN: if (hs) begin
        complete = 1'b1;
        rx_len_d = rx_size_i - cfg_data_i[TRANS_SIZE-1:0];
        state_d  = enable_i ? S_W_RXA : S_C_RX;
      end
`endif
      S_C_RX:  if (hs) state_d = S_C_TX;
      S_C_TX:  if (hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      done_d     = 1'b1;
      done_buf_d = buf_q;
      cnt_d      = cnt_q + 16'd1;
      buf_d      = ~buf_q;
    end

    if (state_d == S_IDLE || (state_d == S_C_RX && state_q != S_C_RX)) pend_d = 1'b0;

    // Request registers load only on state entry so they hold through backpressure.
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef UDMA_SPIS_PP_READBACK_EN
    rwn_d   = rwn_q;
`endif
    if (state_d != state_q) begin
      valid_d = 1'b1;
      addr_d  = 5'h00;
      data_d  = 32'h0;
`ifdef UDMA_SPIS_PP_READBACK_EN
      rwn_d   = 1'b0;
`endif
      case (state_d)
        S_W_RXA: begin addr_d = ADDR_RX_SADDR; data_d = 32'(buf_d ? rx_addr1_i : rx_addr0_i); end
        S_W_RXS: begin addr_d = ADDR_RX_SIZE;  data_d = 32'(rx_size_i); end
        S_W_RXC: begin addr_d = ADDR_RX_CFG;   data_d = CFG_EN; end
        S_W_TXA: begin addr_d = ADDR_TX_SADDR; data_d = 32'(buf_d ? tx_addr1_i : tx_addr0_i); end
        S_W_TXS: begin addr_d = ADDR_TX_SIZE;  data_d = 32'(tx_size_i); end
        S_W_TXC: begin addr_d = ADDR_TX_CFG;   data_d = CFG_EN; end
        S_C_RX:  begin addr_d = ADDR_RX_CFG;   data_d = CFG_CLR; end
        S_C_TX:  begin addr_d = ADDR_TX_CFG;   data_d = CFG_CLR; end
`ifdef UDMA_SPIS_PP_READBACK_EN
        S_RD_LEN: begin addr_d = ADDR_RX_SIZE; rwn_d = 1'b1; end
`endif
        default: valid_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      buf_q      <= 1'b0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      done_buf_q <= 1'b0;
      cnt_q      <= 16'h0;
      valid_q    <= 1'b0;
      addr_q     <= 5'h00;
      data_q     <= 32'h0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      en_q       <= enable_i;
      done_q     <= done_d;
      done_buf_q <= done_buf_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

`ifdef UDMA_SPIS_PP_READBACK_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rwn_q    <= 1'b0;
      rx_len_q <= '0;
    end else begin
      rwn_q    <= rwn_d;
      rx_len_q <= rx_len_d;
    end
  end
  assign cfg_rwn_o = rwn_q;
  assign rx_len_o  = rx_len_q;
`else
  assign cfg_rwn_o = 1'b0;
  assign rx_len_o  = '0;
`endif

  assign cfg_valid_o  = valid_q;
  assign cfg_addr_o   = addr_q;
  assign cfg_data_o   = data_q;
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_ARMED);
  assign armed_o      = (state_q == S_ARMED);
  assign active_buf_o = buf_q;
  assign done_valid_o = done_q;
  assign done_buf_o   = done_buf_q;
  assign xfer_cnt_o   = cnt_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_udma_spis_pingpong_ctrl.sv
`timescale 1ns/1ps
module tb_udma_spis_pingpong_ctrl;
  localparam int AW = 12;
  localparam int TS = 16;
  localparam int K_ARM = 0;
  localparam int K_CLR = 1;
  localparam int K_RD  = 2;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          enable_i = 1'b0;
  logic          seot_i = 1'b0;
  logic [AW-1:0] rx_addr0_i, rx_addr1_i, tx_addr0_i, tx_addr1_i;
  logic [TS-1:0] rx_size_i, tx_size_i;
  logic [31:0]   cfg_data_i;
  logic          cfg_ready_i;
  logic [31:0]   cfg_data_o;
  logic [4:0]    cfg_addr_o;
  logic          cfg_valid_o, cfg_rwn_o, busy_o, armed_o, active_buf_o;
  logic          done_valid_o, done_buf_o, overrun_o;
  logic [15:0]   xfer_cnt_o;
  logic [TS-1:0] rx_len_o;

  always #5 clk_i = ~clk_i;

  udma_spis_pingpong_ctrl #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i),
    .rx_addr0_i(rx_addr0_i), .rx_addr1_i(rx_addr1_i),
    .tx_addr0_i(tx_addr0_i), .tx_addr1_i(tx_addr1_i),
    .rx_size_i(rx_size_i), .tx_size_i(tx_size_i), .seot_i(seot_i),
    .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o), .cfg_valid_o(cfg_valid_o),
    .cfg_rwn_o(cfg_rwn_o), .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i),
    .busy_o(busy_o), .armed_o(armed_o), .active_buf_o(active_buf_o),
    .done_valid_o(done_valid_o), .done_buf_o(done_buf_o), .xfer_cnt_o(xfer_cnt_o),
    .overrun_o(overrun_o), .rx_len_o(rx_len_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queue of expected bus requests ----------------
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rwn;
    int          kind;
  } req_t;
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  req_t          m_q[$];
  wr_t           wr_log[$];
  logic          m_arm, m_buf, m_pend, m_ovr, m_done, m_done_buf, m_en_prev;
  logic [15:0]   m_cnt;
  logic [TS-1:0] m_rxlen;

  function automatic void push_req(input logic [4:0] a, input logic [31:0] d,
                                   input logic r, input int k);
    req_t e;
    e.addr = a; e.data = d; e.rwn = r; e.kind = k;
    m_q.push_back(e);
  endfunction

  function automatic void push_arm(input logic b);
    push_req(5'h00, 32'(b ? rx_addr1_i : rx_addr0_i), 1'b0, K_ARM);
    push_req(5'h01, 32'(rx_size_i), 1'b0, K_ARM);
    push_req(5'h02, 32'h10, 1'b0, K_ARM);
    push_req(5'h04, 32'(b ? tx_addr1_i : tx_addr0_i), 1'b0, K_ARM);
    push_req(5'h05, 32'(tx_size_i), 1'b0, K_ARM);
    push_req(5'h06, 32'h10, 1'b0, K_ARM);
  endfunction

  function automatic void push_clear();
    push_req(5'h02, 32'h40, 1'b0, K_CLR);
    push_req(5'h06, 32'h40, 1'b0, K_CLR);
    m_pend = 1'b0;
  endfunction

  function automatic void model_complete();
    m_done = 1'b1;
    m_done_buf = m_buf;
    m_cnt = m_cnt + 16'd1;
    m_buf = ~m_buf;
    if (enable_i) push_arm(m_buf);
    else          push_clear();
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_arm = 0; m_buf = 0; m_pend = 0; m_ovr = 0; m_done = 0; m_done_buf = 0;
    m_en_prev = 0; m_cnt = '0; m_rxlen = '0;
  endfunction

  // Predicts the outputs after the next rising edge from the inputs now applied.
  function automatic void model_step();
    logic busy, hs;
    req_t f;
    busy = (m_q.size() != 0);
    hs   = busy && cfg_ready_i;
    m_done = 1'b0;
    if (enable_i && !m_en_prev) m_ovr = 1'b0;
    if (busy && seot_i) begin
      if (m_pend) m_ovr = 1'b1;
      else        m_pend = 1'b1;
    end
    if (!busy && !m_arm) begin
      if (enable_i) begin
        m_buf = 1'b0;
        push_arm(1'b0);
      end
    end else if (!busy) begin
      if (seot_i || m_pend) begin
        m_pend = m_pend && seot_i;
        m_arm  = 1'b0;
`ifdef UDMA_SPIS_PP_READBACK_EN
        push_req(5'h01, 32'h0, 1'b1, K_RD);
`else
        model_complete();
`endif
      end else if (!enable_i) begin
        m_arm = 1'b0;
        push_clear();
      end
    end else if (hs) begin
      f = m_q.pop_front();
      if (f.kind == K_RD) begin
        m_rxlen = rx_size_i - cfg_data_i[TS-1:0];
        model_complete();
      end else if (f.kind == K_ARM && !enable_i) begin
        m_q.delete();
        push_clear();
      end else if (m_q.size() == 0) begin
        if (f.kind == K_ARM) m_arm = 1'b1;
        else                 m_pend = 1'b0;
      end
    end
    m_en_prev = enable_i;
  endfunction

  // ---------------- compare process ----------------
  logic        prev_v = 0, prev_r = 0;
  logic [4:0]  prev_a = 0;
  logic [31:0] prev_d = 0;

  always @(negedge clk_i) begin
    if (!rstn_i) begin
      model_reset();
      prev_v = 0;
    end else begin
      chk("cfg_valid", 32'(cfg_valid_o), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("cfg_addr", 32'(cfg_addr_o), 32'(m_q[0].addr));
        chk("cfg_data", cfg_data_o, m_q[0].data);
        chk("cfg_rwn", 32'(cfg_rwn_o), 32'(m_q[0].rwn));
      end
      chk("busy", 32'(busy_o), 32'(m_q.size() != 0));
      chk("armed", 32'(armed_o), 32'(m_arm));
      chk("active_buf", 32'(active_buf_o), 32'(m_buf));
      chk("done_valid", 32'(done_valid_o), 32'(m_done));
      if (m_done) chk("done_buf", 32'(done_buf_o), 32'(m_done_buf));
      chk("xfer_cnt", 32'(xfer_cnt_o), 32'(m_cnt));
      chk("overrun", 32'(overrun_o), 32'(m_ovr));
      chk("rx_len", 32'(rx_len_o), 32'(m_rxlen));
      if (prev_v && !prev_r) begin
        chk("hold_valid", 32'(cfg_valid_o), 32'd1);
        chk("hold_addr", 32'(cfg_addr_o), 32'(prev_a));
        chk("hold_data", cfg_data_o, prev_d);
      end
      prev_v = cfg_valid_o; prev_r = cfg_ready_i; prev_a = cfg_addr_o; prev_d = cfg_data_o;
      if (cfg_valid_o && cfg_ready_i && !cfg_rwn_o) begin
        wr_t w;
        w.a = cfg_addr_o; w.d = cfg_data_o;
        wr_log.push_back(w);
      end
      model_step();
    end
  end

  // ---------------- ready / read-data driver ----------------
  int ready_mode = 0;   // 0 always ready, 1 three stall cycles per request, 2 random
  int rdata_mode = 0;   // 0 returns 0x08, 1 random
  int age = 0;
  always @(posedge clk_i) begin
    if (cfg_valid_o && !cfg_ready_i) age++;
    else                             age = 0;
    #2;
    case (ready_mode)
      0:       cfg_ready_i = 1'b1;
      1:       cfg_ready_i = (age >= 3);
      default: cfg_ready_i = ($urandom_range(3) != 0);
    endcase
    cfg_data_i = (rdata_mode == 0) ? 32'h8 : $urandom;
  end

  // ---------------- helpers ----------------
  task automatic drive_en(input logic v);
    @(posedge clk_i); #2 enable_i = v;
  endtask

  task automatic pulse_seot();
    @(posedge clk_i); #2 seot_i = 1'b1;
    @(posedge clk_i); #2 seot_i = 1'b0;
  endtask

  task automatic wait_armed(input int n, input string nm);
    logic ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (armed_o) begin ok = 1'b1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int n, input string nm);
    logic ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (!busy_o && !armed_o) begin ok = 1'b1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int n, input string nm, output int cyc);
    logic ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (done_valid_o) begin ok = 1'b1; cyc = i + 1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  logic [4:0]  exp_a [6] = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h05, 5'h06};
  logic [31:0] exp_d [6] = '{32'h100, 32'h20, 32'h10, 32'h200, 32'h20, 32'h10};

  task automatic check_arm_table(input string nm);
    chk({nm, "_nwr"}, 32'(wr_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_log.size()) begin
        chk({nm, "_addr"}, 32'(wr_log[i].a), 32'(exp_a[i]));
        chk({nm, "_data"}, wr_log[i].d, exp_d[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    rx_addr0_i = 12'h100; rx_addr1_i = 12'h180;
    tx_addr0_i = 12'h200; tx_addr1_i = 12'h280;
    rx_size_i  = 16'h20;  tx_size_i  = 16'h20;

    repeat (3) @(negedge clk_i);
    chk("rst_valid", 32'(cfg_valid_o), 32'd0);
    chk("rst_addr", 32'(cfg_addr_o), 32'd0);
    chk("rst_data", cfg_data_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_armed", 32'(armed_o), 32'd0);
    chk("rst_done", 32'(done_valid_o), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    chk("rst_buf", 32'(active_buf_o), 32'd0);
    chk("rst_rxlen", 32'(rx_len_o), 32'd0);
    @(posedge clk_i); #2 rstn_i = 1'b1;

    // arm buffer 0
    repeat (2) @(posedge clk_i);
    wr_log.delete();
    drive_en(1'b1);
    wait_armed(40, "arm_timeout");
    check_arm_table("arm");
    chk("arm_busy", 32'(busy_o), 32'd0);

    // ping-pong: first completion
    wr_log.delete();
    pulse_seot();
    wait_done(20, "pp1_timeout", cyc);
`ifdef UDMA_SPIS_PP_READBACK_EN
    chk("pp1_latency", 32'(cyc), 32'd2);
    chk("pp1_rxlen", 32'(rx_len_o), 32'h18);
`else
    chk("pp1_latency", 32'(cyc), 32'd1);
    chk("pp1_valid_latency", 32'(cfg_valid_o), 32'd1);
`endif
    chk("pp1_done_buf", 32'(done_buf_o), 32'd0);
    chk("pp1_cnt", 32'(xfer_cnt_o), 32'd1);
    wait_armed(40, "pp1_arm_timeout");
    chk("pp1_nwr", 32'(wr_log.size()), 32'd6);
    if (wr_log.size() == 6) begin
      chk("pp1_rxaddr1", wr_log[0].d, 32'h180);
      chk("pp1_txaddr1", wr_log[3].d, 32'h280);
    end

    // second completion returns to buffer 0
    wr_log.delete();
    pulse_seot();
    wait_done(20, "pp2_timeout", cyc);
    chk("pp2_done_buf", 32'(done_buf_o), 32'd1);
    chk("pp2_cnt", 32'(xfer_cnt_o), 32'd2);
    wait_armed(40, "pp2_arm_timeout");
    check_arm_table("pp2");

    // disable from ARMED
    wr_log.delete();
    drive_en(1'b0);
    wait_idle(40, "dis_timeout");
    chk("dis_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("dis_a0", 32'(wr_log[0].a), 32'h02);
      chk("dis_d0", wr_log[0].d, 32'h40);
      chk("dis_a1", 32'(wr_log[1].a), 32'h06);
      chk("dis_d1", wr_log[1].d, 32'h40);
    end
    chk("dis_busy", 32'(busy_o), 32'd0);

    // backpressure: three stall cycles per request
    ready_mode = 1;
    wr_log.delete();
    drive_en(1'b1);
    wait_armed(100, "bp_timeout");
    check_arm_table("bp");

    // overrun: two seot pulses during one programming sequence
    drive_en(1'b0);
    wait_idle(60, "ovr_idle_timeout");
    drive_en(1'b1);
    pulse_seot();
    pulse_seot();
    wait_done(100, "ovr_done_timeout", cyc);
    chk("ovr_done_buf", 32'(done_buf_o), 32'd0);
    chk("ovr_cnt", 32'(xfer_cnt_o), 32'd3);
    chk("ovr_flag", 32'(overrun_o), 32'd1);
    wait_armed(100, "ovr_arm_timeout");
    chk("ovr_cnt_after", 32'(xfer_cnt_o), 32'd3);
    drive_en(1'b0);
    wait_idle(60, "ovr_dis_timeout");
    chk("ovr_sticky", 32'(overrun_o), 32'd1);
    drive_en(1'b1);
    repeat (2) @(negedge clk_i);
    chk("ovr_cleared", 32'(overrun_o), 32'd0);
    drive_en(1'b0);
    wait_idle(100, "ovr_end_timeout");

    // randomized run against the model
    @(posedge clk_i); #2;
    rx_addr0_i = AW'($urandom); rx_addr1_i = AW'($urandom);
    tx_addr0_i = AW'($urandom); tx_addr1_i = AW'($urandom);
    rx_size_i  = TS'($urandom); tx_size_i  = TS'($urandom);
    ready_mode = 2;
    rdata_mode = 1;
    drive_en(1'b1);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk_i); #2;
      seot_i = ($urandom_range(24) == 0);
      if ($urandom_range(299) == 0) enable_i = ~enable_i;
    end
    seot_i = 1'b0;
    enable_i = 1'b0;
    wait_idle(200, "rand_end_timeout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
